// File: rtl/spi_pkg.sv
// Shared state encoding and command codes for the SPI front end of the single-port RAM.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_rx.sv
// Serial-in MSB-first shift register with a saturating bit counter; done marks the edge
// that samples the last bit of a CW-bit word.
module spi_shift_rx
  import spi_pkg::*;
#(
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          mosi,
  output logic [CW-1:0] word_o,
  output logic          done_o,
  output logic          full_o
);

  // one extra count value so the counter can hold CW without wrapping for any CW
  localparam int unsigned CNT_W = $clog2(CW + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW);

  logic [CW-2:0]    shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    word_o  = {shift_q, mosi};
    done_o  = en && (cnt_q == CNT_LAST);
    full_o  = (cnt_q == CNT_FULL);
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (en && (cnt_q != CNT_FULL)) begin
      shift_d = word_o[CW-2:0];
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: deserialises {cmd, payload} words for the RAM and shifts read data back out on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned CW    = DATA_W + 2;
  localparam int unsigned TXC_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic              rd_seen_q, rd_seen_d;
  logic [CW-1:0]     rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_act_q, tx_act_d;
  logic              tx_fin_q, tx_fin_d;

  logic          sh_en, sh_done, sh_full;
  logic [CW-1:0] sh_word;

  assign sh_en = !SS_n && (state_q inside {WRITE, READ_ADD, READ_DATA});

  spi_shift_rx #(.CW(CW)) u_shift_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (SS_n),
    .en     (sh_en),
    .mosi   (MOSI),
    .word_o (sh_word),
    .done_o (sh_done),
    .full_o (sh_full)
  );

  always_comb begin
    state_d    = state_q;
    rd_seen_d  = rd_seen_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = 1'b0;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_act_d   = tx_act_q;
    tx_fin_d   = tx_fin_q;
    if (SS_n) begin
      state_d  = IDLE;
      tx_act_d = 1'b0;
      tx_fin_d = 1'b0;
      tx_cnt_d = '0;
    end else begin
      if (sh_done) begin
        rx_data_d  = sh_word;
        rx_valid_d = 1'b1;
      end
      unique case (state_q)
        IDLE:      state_d = CHK_CMD;
        CHK_CMD:   state_d = MOSI ? (rd_seen_q ? READ_DATA : READ_ADD) : WRITE;
        WRITE:     ;
        READ_ADD:  if (sh_done) rd_seen_d = 1'b1;
        READ_DATA: begin
          if (sh_done) rd_seen_d = 1'b0;
          // tx_valid only matters once the command word is in and no shift-out has happened yet
          if (tx_act_q) begin
            if (tx_cnt_q != '0) begin
              miso_d   = tx_sh_q[DATA_W-2];
              tx_sh_d  = tx_sh_q << 1;
              tx_cnt_d = tx_cnt_q - TXC_W'(1);
            end else begin
              tx_act_d = 1'b0;
              tx_fin_d = 1'b1;
            end
          end else if (sh_full && !tx_fin_q && tx_valid) begin
            miso_d   = tx_data[DATA_W-1];
            tx_sh_d  = tx_data;
            tx_cnt_d = TXC_W'(DATA_W - 1);
            tx_act_d = 1'b1;
          end
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_seen_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      tx_act_q   <= 1'b0;
      tx_fin_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_seen_q  <= rd_seen_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_act_q   <= tx_act_d;
      tx_fin_q   <= tx_fin_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: command frames, read-data shift-out, aborts and async reset.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pulses = 0;
  int unsigned exp_pulses = 0;

  spi_slave #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic dir, input logic [9:0] w);
    SS_n = 1'b0;
    tick();
    MOSI = dir;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      tick();
    end
  endtask

  task automatic frame_check(input string tag, input logic dir, input logic [9:0] w);
    send_frame(dir, w);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, w);
    exp_pulses++;
    tick();
    check({tag, "_valid_low"}, rx_valid, 0);
    check({tag, "_pulses"}, pulses, exp_pulses);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
  endtask

  task automatic quiet(input string tag);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check({tag, "_miso0"}, MISO, 0);
    tick();
    check({tag, "_miso1"}, MISO, 0);
  endtask

  task automatic tx_send(input string tag, input logic [7:0] d, input bit glitch);
    logic [7:0] dv;
    dv       = d;
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("%s_bit%0d", tag, i), MISO, dv[i]);
      if (i > 0) begin
        if (glitch && i == 4) begin
          tx_data  = ~d;
          tx_valid = 1'b1;
        end
        tick();
        tx_valid = 1'b0;
      end
    end
    tick();
    check({tag, "_tail0"}, MISO, 0);
    tick();
    check({tag, "_tail1"}, MISO, 0);
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    #12;
    check("rst_miso", MISO, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    tick();

    frame_check("wr_addr", 1'b0, {CMD_WR_ADDR, 8'h05});
    end_frame();
    frame_check("wr_data", 1'b0, {CMD_WR_DATA, 8'hAA});
    MOSI = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("extra_bits_pulses", pulses, exp_pulses);
    check("extra_bits_data", rx_data, 10'h1AA);
    quiet("tx_in_write");
    end_frame();
    quiet("tx_in_idle");

    frame_check("rd_addr", 1'b1, {CMD_RD_ADDR, 8'h05});
    quiet("tx_in_read_add");
    end_frame();
    frame_check("rd_data", 1'b1, {CMD_RD_DATA, 8'hC4});
    check("miso_wait", MISO, 0);
    tx_send("tx_a5", 8'hA5, 1'b1);
    end_frame();

    // rd_addr_seen cleared by the read-data frame: next read goes to READ_ADD
    frame_check("rd_addr2", 1'b1, 10'h2FF);
    quiet("tx_after_clear");
    end_frame();
    frame_check("rd_data2", 1'b1, 10'h300);
    tx_send("tx_3c", 8'h3C, 1'b0);
    end_frame();

    SS_n = 1'b0; tick();
    MOSI = 1'b0; tick();
    MOSI = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    end_frame();
    check("abort_valid", rx_valid, 0);
    check("abort_pulses", pulses, exp_pulses);
    check("abort_data", rx_data, 10'h300);
    frame_check("after_abort", 1'b0, 10'h0F0);
    end_frame();

    frame_check("rd_addr3", 1'b1, 10'h211);
    end_frame();
    frame_check("rd_data3", 1'b1, 10'h3AB);
    tx_data = 8'hFF; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    check("ss_abort_miso_hi", MISO, 1);
    end_frame();
    check("ss_abort_miso_lo", MISO, 0);

    send_frame(1'b1, 10'h255);
    check("rst1_pre_valid", rx_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst1_valid", rx_valid, 0);
    check("rst1_data", rx_data, 0);
    check("rst1_miso", MISO, 0);
    rst_n = 1'b1;
    end_frame();
    check("rst1_pulses", pulses, exp_pulses);
    frame_check("post_rst", 1'b1, 10'h2AA);
    quiet("rd_seen_reset");
    end_frame();

    frame_check("rd_data4", 1'b1, 10'h3FF);
    tx_data = 8'hFF; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    tick();
    check("rst2_pre_miso", MISO, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_miso", MISO, 0);
    rst_n = 1'b1;
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
